vga_text_renderer: RTL and testbench
====================================

# vga_text_renderer

Text-mode pixel source that sits between the VGA timing generator and the board DAC pins. It takes the generator's pixel counters, syncs and blank, and keeps a character buffer that the CPU writes. Glyph rows come from an external font ROM. It drives VGA_R/G/B together with HS/VS/BLANK_N, delayed so that all of them stay pixel-aligned.

## Interface
Parameters:
- COLS, 25: characters per row.
- ROWS, 37: character rows.
- GLYPH_H, 16: scanlines per glyph (glyph width is fixed at 8).
- FG_RGB, 24'hFFFFFF: foreground colour.
- BG_RGB, 24'h000000: background colour.
- BORDER_RGB, 24'h000080: colour for active pixels outside the COLS×8 by ROWS×GLYPH_H area.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel strobe; high for one CLOCK_50 cycle per pixel; minimum spacing 2 cycles.
- h_count  in  9  horizontal pixel index from the timing generator.
- v_count  in  10  line index.
- active_in  in  1  1 = visible pixel.
- hs_in / vs_in  in  1 each  sync from the timing generator; active-high.
- cpu_we  in  1  write strobe, one cycle.
- cpu_addr  in  11  write address.
- cpu_wdata  in  8  write data.
- font_addr  out  12  {char_code[7:0], glyph_line[3:0]}.
- font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 cycle after font_addr changes.
- VGA_R / VGA_G / VGA_B  out  8 each  pixel colour.
- VGA_HS / VGA_VS  out  1 each  delayed hs_in / vs_in.
- VGA_BLANK_N  out  1  delayed active_in.

## Operation
- CPU port:
  - cpu_addr < COLS*ROWS: writes the char buffer.
  - 0x7FE: writes cursor_col (5 bits).
  - 0x7FF: writes cursor_row (6 bits).
  - Any other address is ignored.
- Pipeline. It advances only on pix_en; all stage registers hold between strobes.
  - S0: col = h_count>>3, row = v_count/GLYPH_H, line = v_count%GLYPH_H. Issue char read at row*COLS+col (11 bits, unsigned). Capture in_area, xbit = h_count[2:0], is_cursor, and syncs/active.
  - S1: char code returns. Drive font_addr = {code, line}.
  - S2: font_data returns. pix = font_data[7-xbit]. If is_cursor, blink_on and line ≥ GLYPH_H-2, pix is inverted.
  - S3 (output register):
    - RGB = 0 when !active.
    - Otherwise RGB = BORDER_RGB when !in_area.
    - Otherwise RGB = pix ? FG_RGB : BG_RGB.
- Blink: a 5-bit frame counter increments on each vs_in rising edge, sampled on pix_en. blink_on = counter[4], which toggles every 16 frames.
- Char buffer:
  - Simultaneous CPU write and display read of the same address: the display gets the old data, the write lands.
  - Buffer contents are not reset.

## Timing
- Latency: every output reflects the inputs sampled 3 pix_en strobes earlier. HS, VS, BLANK_N and RGB shift together, so the relative sync/pixel alignment of the generator is preserved.
- Char buffer and font read: each address is registered on a strobe. Data is valid 1 CLOCK_50 cycle later and is captured at the next strobe. This is why pix_en spacing must be at least 2 cycles.
- Reset values, all applied asynchronously:
  - VGA_R/G/B = 0, VGA_HS = 0, VGA_VS = 0, VGA_BLANK_N = 0.
  - font_addr = 0.
  - Pipeline valid and sync shadows = 0.
  - cursor_col = cursor_row = 0, blink counter = 0.
- Reset deasserted mid-frame: outputs stay blanked until the first 3 strobes have refilled the pipeline. There are no stale pixels.
- A CPU write takes effect for the first S0 issued at least 1 cycle after cpu_we.
- Range edges:
  - col ≥ COLS or row ≥ ROWS gives in_area = 0.
  - Default config: lines 592–599 are border.
  - The char address is never issued out of range; it is forced to 0 when !in_area.

## Structure
- vga_pkg holds:
  - rgb_t (struct of three 8-bit fields).
  - GLYPH_W = 8.
  - CURSOR_COL_ADDR = 11'h7FE, CURSOR_ROW_ADDR = 11'h7FF.
  - Default COLS/ROWS/GLYPH_H.
- Sub-module text_ram: simple dual-port 2048×8. Write port on the CPU side, registered read port on the display side, read-before-write. It is inferred as block RAM.
- Everything else (pipeline, cursor, blink) lives in vga_text_renderer.

## Test plan
- Reset then idle strobes → all VGA outputs 0. BLANK_N rises exactly 3 strobes after active_in rises.
- Write 0x41 to address 0; font model returns 0x81 for code 0x41 line 0. Pixel (0,0) → FG_RGB. Pixels (1..6,0) → BG_RGB. Pixel (7,0) → FG_RGB. Each appears 3 strobes after its h_count.
- v_count = 595, active_in = 1 → BORDER_RGB. active_in = 0 → RGB 0. hs_in pulse reappears on VGA_HS delayed exactly 3 strobes.
- Cursor at (2,1) via 0x7FE/0x7FF, cell blank (font 0x00). After 16 vs_in edges, lines 30–31 of cell (2,1) → FG_RGB. After 32 edges → BG_RGB again.
- Write to 0x500 (out of range) → buffer and cursor unchanged. Simultaneous write and display read of the same address → old code shown on that pixel, new code on the next frame.
- Assert RESET_N low mid-line → outputs 0 within the same cycle. Release → first valid pixel appears 3 strobes later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the text-mode VGA renderer.
// Also holds the per-stage pipeline records passed between pixel stages.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int GLYPH_W = 8;

  localparam logic [10:0] CURSOR_COL_ADDR = 11'h7FE;
  localparam logic [10:0] CURSOR_ROW_ADDR = 11'h7FF;

  localparam int DEFAULT_COLS    = 25;
  localparam int DEFAULT_ROWS    = 37;
  localparam int DEFAULT_GLYPH_H = 16;

  // Pixel attributes carried from S0 through S1 alongside the memory reads.
  typedef struct packed {
    logic       valid;
    logic       active;
    logic       hs;
    logic       vs;
    logic       in_area;
    logic       is_cursor;
    logic [3:0] line;
    logic [2:0] xbit;
  } stage_t;

  // After S2 only the resolved pixel bit and the output qualifiers remain.
  typedef struct packed {
    logic valid;
    logic active;
    logic hs;
    logic vs;
    logic in_area;
    logic pix;
  } late_t;

  function automatic rgb_t to_rgb(input logic [23:0] value);
    rgb_t c;
    c.r = value[23:16];
    c.g = value[15:8];
    c.b = value[7:0];
    return c;
  endfunction

endpackage

// File: rtl/vga_text_renderer_text_ram.sv
// Character buffer: CPU write port, display read port registered on the pixel strobe.
// A read and a write to the same address in one cycle returns the old contents.
module text_ram
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  input  logic [10:0] rd_addr,
  output logic [7:0]  rd_data
);

  logic [7:0] mem [0:2047];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel source: character buffer + external font ROM -> RGB, with the
// sync and blank signals delayed through the same three-strobe pipeline.
module vga_text_renderer
  import vga_pkg::*;
#(
  parameter int          COLS       = DEFAULT_COLS,
  parameter int          ROWS       = DEFAULT_ROWS,
  parameter int          GLYPH_H    = DEFAULT_GLYPH_H,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000,
  parameter logic [23:0] BORDER_RGB = 24'h000080
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        pix_en,
  input  logic [8:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        active_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);

  localparam logic [10:0] CELLS       = 11'(COLS * ROWS);
  localparam logic [10:0] COLS_A      = 11'(COLS);
  localparam logic [9:0]  COLS_W      = 10'(COLS);
  localparam logic [9:0]  ROWS_W      = 10'(ROWS);
  localparam logic [9:0]  GLYPH_H_W   = 10'(GLYPH_H);
  localparam logic [3:0]  CURSOR_LINE = 4'(GLYPH_H - 2);

  logic [4:0]  cursor_col_reg;
  logic [5:0]  cursor_row_reg;
  logic [4:0]  blink_cnt_reg;
  logic [4:0]  blink_cnt_next;
  logic        vs_prev_reg;

  logic [5:0]  s0_col;
  logic [9:0]  s0_row;
  logic [3:0]  s0_line;
  logic        s0_in_area;
  logic        s0_is_cursor;
  logic [10:0] s0_char_addr;
  stage_t      stage0_next;

  stage_t      s0_q;
  stage_t      s1_q;
  logic        s1_pix;
  late_t       late_reg;
  logic [7:0]  ram_rd_data;
  logic        ram_we;
  logic [11:0] font_addr_reg;

  rgb_t        rgb_reg;
  rgb_t        rgb_next;
  logic        hs_reg;
  logic        vs_reg;
  logic        blank_n_reg;

  // CPU side: buffer writes and cursor registers share one address space.
  assign ram_we = cpu_we && (cpu_addr < CELLS);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cursor_col_reg <= '0;
      cursor_row_reg <= '0;
    end else if (cpu_we) begin
      if (cpu_addr == CURSOR_COL_ADDR) begin
        cursor_col_reg <= cpu_wdata[4:0];
      end
      if (cpu_addr == CURSOR_ROW_ADDR) begin
        cursor_row_reg <= cpu_wdata[5:0];
      end
    end
  end

  // Frame counter for the cursor blink, stepped on vsync rising edges.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    if (vs_in && !vs_prev_reg) begin
      blink_cnt_next = blink_cnt_reg + 5'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_prev_reg   <= 1'b0;
      blink_cnt_reg <= '0;
    end else if (pix_en) begin
      vs_prev_reg   <= vs_in;
      blink_cnt_reg <= blink_cnt_next;
    end
  end

  // S0: locate the character cell; out-of-area pixels read address 0.
  always_comb begin
    s0_col       = h_count[8:3];
    s0_row       = v_count / GLYPH_H_W;
    s0_line      = 4'(v_count % GLYPH_H_W);
    s0_in_area   = ({4'b0, s0_col} < COLS_W) && (s0_row < ROWS_W);
    s0_char_addr = '0;
    if (s0_in_area) begin
      s0_char_addr = 11'({1'b0, s0_row} * COLS_A + {5'b0, s0_col});
    end
    s0_is_cursor = s0_in_area && (s0_col == {1'b0, cursor_col_reg}) &&
                   (s0_row == {4'b0, cursor_row_reg});
    stage0_next = '{valid:     1'b1,
                    active:    active_in,
                    hs:        hs_in,
                    vs:        vs_in,
                    in_area:   s0_in_area,
                    is_cursor: s0_is_cursor,
                    line:      s0_line,
                    xbit:      h_count[2:0]};
  end

  text_ram u_text_ram (
    .clk     (CLOCK_50),
    .wr_en   (ram_we),
    .wr_addr (cpu_addr),
    .wr_data (cpu_wdata),
    .rd_en   (pix_en),
    .rd_addr (s0_char_addr),
    .rd_data (ram_rd_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stage
      stage_t pipe_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
          if (!RESET_N) begin
            pipe_reg <= '0;
          end else if (pix_en) begin
            pipe_reg <= stage0_next;
          end
        end
      end else begin : g_next
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
          if (!RESET_N) begin
            pipe_reg <= '0;
          end else if (pix_en) begin
            pipe_reg <= g_stage[gi-1].pipe_reg;
          end
        end
      end
    end
  endgenerate

  assign s0_q = g_stage[0].pipe_reg;
  assign s1_q = g_stage[1].pipe_reg;

  // S1: the character code is back from the buffer; address the font ROM.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      font_addr_reg <= '0;
    end else if (pix_en) begin
      font_addr_reg <= {ram_rd_data, s0_q.line};
    end
  end

  assign font_addr = font_addr_reg;

  // S2: pick the glyph bit; the cursor underlines the bottom two scanlines.
  always_comb begin
    s1_pix = font_data[3'd7 - s1_q.xbit];
    if (s1_q.is_cursor && blink_cnt_reg[4] && (s1_q.line >= CURSOR_LINE)) begin
      s1_pix = ~s1_pix;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      late_reg <= '0;
    end else if (pix_en) begin
      late_reg <= '{valid:   s1_q.valid,
                    active:  s1_q.active,
                    hs:      s1_q.hs,
                    vs:      s1_q.vs,
                    in_area: s1_q.in_area,
                    pix:     s1_pix};
    end
  end

  // S3: colour selection into the output register.
  always_comb begin
    rgb_next = '0;
    if (late_reg.valid && late_reg.active) begin
      if (!late_reg.in_area) begin
        rgb_next = to_rgb(BORDER_RGB);
      end else if (late_reg.pix) begin
        rgb_next = to_rgb(FG_RGB);
      end else begin
        rgb_next = to_rgb(BG_RGB);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_reg     <= '0;
      hs_reg      <= 1'b0;
      vs_reg      <= 1'b0;
      blank_n_reg <= 1'b0;
    end else if (pix_en) begin
      rgb_reg     <= rgb_next;
      hs_reg      <= late_reg.hs;
      vs_reg      <= late_reg.vs;
      blank_n_reg <= late_reg.valid && late_reg.active;
    end
  end

  assign VGA_R       = rgb_reg.r;
  assign VGA_G       = rgb_reg.g;
  assign VGA_B       = rgb_reg.b;
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_BLANK_N = blank_n_reg;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Randomised bench for vga_text_renderer against a behavioural pixel model.
module tb_vga_text_renderer;

  localparam int COLS = 25;
  localparam int ROWS = 37;
  localparam int GH   = 16;
  localparam logic [23:0] FG     = 24'hFFFFFF;
  localparam logic [23:0] BG     = 24'h000000;
  localparam logic [23:0] BORDER = 24'h000080;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        pix_en = 1'b0;
  logic [8:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        active_in = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_text_renderer dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count), .active_in(active_in),
    .hs_in(hs_in), .vs_in(vs_in), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .font_addr(font_addr), .font_data(font_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
  );

  function automatic logic [7:0] font_model(input logic [7:0] code, input logic [3:0] line);
    if (code == 8'h41 && line == 4'd0) return 8'h81;
    if (code == 8'h00) return 8'h00;
    return code ^ {line, ~line};
  endfunction

  // Synchronous font ROM: data follows the address by one clock.
  always @(posedge CLOCK_50) font_data <= font_model(font_addr[11:4], font_addr[3:0]);

  int checks = 0;
  int errors = 0;

  logic [7:0]  mbuf [0:2047];
  int          mcol = 0;
  int          mrow = 0;
  int          mblink = 0;
  bit          mvs_prev = 1'b0;
  logic [26:0] exp_q [$];

  // Expected {rgb, hs, vs, blank_n} for one sampled input pixel.
  function automatic logic [26:0] model_px(int h, int v, bit act, bit hs, bit vs);
    int col, row, line;
    logic [7:0] g;
    bit pix;
    logic [23:0] rgb;
    col = h / 8;
    row = v / GH;
    line = v % GH;
    if (!act) rgb = 24'h0;
    else if (col >= COLS || row >= ROWS) rgb = BORDER;
    else begin
      g = font_model(mbuf[row * COLS + col], 4'(line));
      pix = g[7 - (h % 8)];
      if (col == mcol && row == mrow && mblink >= 16 && line >= GH - 2) pix = !pix;
      rgb = pix ? FG : BG;
    end
    return {rgb, hs, vs, act};
  endfunction

  function automatic logic [26:0] obs();
    return {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
  endfunction

  task automatic model_write(input int addr, input int data);
    if (addr < COLS * ROWS) mbuf[addr] = 8'(data);
    else if (addr == 'h7FE) mcol = data & 31;
    else if (addr == 'h7FF) mrow = data & 63;
  endtask

  task automatic model_reset();
    mcol = 0; mrow = 0; mblink = 0; mvs_prev = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(27'd0);
  endtask

  task automatic cpu_write(input int addr, input int data);
    @(posedge CLOCK_50); #1;
    cpu_we = 1'b1; cpu_addr = 11'(addr); cpu_wdata = 8'(data);
    model_write(addr, data);
    @(posedge CLOCK_50); #1;
    cpu_we = 1'b0;
  endtask

  // One pixel strobe (optionally with a same-cycle CPU write); returns the
  // value the outputs must show right after this strobe.
  task automatic strobe(input int h, input int v, input bit act, input bit hs, input bit vs,
                        input bit we, input int addr, input int data, output logic [26:0] e);
    @(posedge CLOCK_50); #1;
    h_count = 9'(h); v_count = 10'(v); active_in = act; hs_in = hs; vs_in = vs;
    pix_en = 1'b1;
    cpu_we = we; cpu_addr = 11'(addr); cpu_wdata = 8'(data);
    exp_q.push_back(model_px(h, v, act, hs, vs));
    if (vs && !mvs_prev) mblink = (mblink + 1) % 32;
    mvs_prev = vs;
    if (we) model_write(addr, data);
    @(posedge CLOCK_50); #1;
    pix_en = 1'b0; cpu_we = 1'b0;
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [26:0] e;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if (obs() !== 27'd0 || font_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: got %h/%h expected 0/0", obs(), font_addr);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(i * 8, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic init_buffer();
    for (int a = 0; a < COLS * ROWS; a++) cpu_write(a, int'($urandom_range(1, 255)));
  endtask

  task automatic test_border_blank();
    logic [26:0] e;
    int blank_at, hs_at;
    blank_at = -1; hs_at = -1;
    for (int i = 0; i < 10; i++) begin
      strobe(int'($urandom_range(0, 199)), 595, (i < 4), (i == 2), 1'b0, 1'b0, 0, 0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL border_blank[%0d]: got %h expected %h", i, obs(), e);
      end
      if (VGA_BLANK_N === 1'b1 && blank_at < 0) blank_at = i;
      if (VGA_HS === 1'b1 && hs_at < 0) hs_at = i;
    end
    checks++;
    if (blank_at !== 3 || hs_at !== 5) begin
      errors++;
      $display("FAIL blank_hs_delay: got blank@%0d hs@%0d expected blank@3 hs@5", blank_at, hs_at);
    end
  endtask

  task automatic test_glyph();
    logic [26:0] e;
    logic [23:0] rgb_seen [0:10];
    cpu_write(0, 8'h41);
    for (int i = 0; i < 11; i++) begin
      strobe(i, 0, (i < 8), 1'b0, 1'b0, 1'b0, 0, 0, e);
      rgb_seen[i] = {VGA_R, VGA_G, VGA_B};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL glyph[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    checks++;
    if (rgb_seen[3] !== FG || rgb_seen[5] !== BG || rgb_seen[10] !== FG) begin
      errors++;
      $display("FAIL glyph_edges: got %h %h %h expected %h %h %h",
               rgb_seen[3], rgb_seen[5], rgb_seen[10], FG, BG, FG);
    end
  endtask

  task automatic vsync_pulses(input int n);
    logic [26:0] e;
    for (int i = 0; i < 2 * n; i++) begin
      strobe(0, 620, 1'b0, 1'b0, ((i % 2) == 0), 1'b0, 0, 0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL vsync[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic render_cursor_cell(input logic [23:0] want_low, input string tag);
    logic [26:0] e;
    logic [23:0] last_low;
    last_low = 24'h0;
    for (int i = 0; i < 27; i++) begin
      strobe(16 + (i % 8), 29 + (i / 8) % 3, (i < 24), 1'b0, 1'b0, 1'b0, 0, 0, e);
      if (i >= 19 && i < 27) last_low = {VGA_R, VGA_G, VGA_B};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %h expected %h", tag, i, obs(), e);
      end
    end
    checks++;
    if (last_low !== want_low) begin
      errors++;
      $display("FAIL %s_line31: got %h expected %h", tag, last_low, want_low);
    end
  endtask

  task automatic test_cursor_on();
    cpu_write('h7FE, 2);
    cpu_write('h7FF, 1);
    cpu_write(27, 8'h00);
    vsync_pulses(16);
    render_cursor_cell(FG, "cursor_on");
  endtask

  task automatic test_out_of_range();
    cpu_write('h500, 8'hAA);
    cpu_write('h7FD, 8'h05);
    cpu_write('h7FC, 8'h07);
    render_cursor_cell(FG, "out_of_range");
  endtask

  task automatic test_cursor_off();
    vsync_pulses(16);
    render_cursor_cell(BG, "cursor_off");
  endtask

  task automatic test_back_to_back();
    logic [26:0] e;
    logic [23:0] first_rgb, second_rgb;
    cpu_write(80, 8'h41);
    first_rgb = 24'h0; second_rgb = 24'h0;
    for (int i = 0; i < 8; i++) begin
      strobe(40, 48, (i == 0 || i == 4), 1'b0, 1'b0, (i == 0), 80, 8'h00, e);
      if (i == 3) first_rgb = {VGA_R, VGA_G, VGA_B};
      if (i == 7) second_rgb = {VGA_R, VGA_G, VGA_B};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    checks++;
    if (first_rgb !== FG || second_rgb !== BG) begin
      errors++;
      $display("FAIL read_before_write: got %h then %h expected %h then %h",
               first_rgb, second_rgb, FG, BG);
    end
  endtask

  task automatic test_random();
    logic [26:0] e;
    int addr;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range('h7FE, 'h7FF))
                                           : int'($urandom_range(0, COLS * ROWS - 1));
        cpu_write(addr, int'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(0, 2)) @(posedge CLOCK_50);
      strobe(int'($urandom_range(0, 319)), int'($urandom_range(0, 639)),
             bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 1'b0,
             1'b0, 0, 0, e);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [26:0] e;
    int first_valid;
    for (int i = 0; i < 4; i++) strobe(8 * i, 100, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, e);
    @(posedge CLOCK_50); #3;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (obs() !== 27'd0 || font_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_midline: got %h/%h expected 0/0", obs(), font_addr);
    end
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    first_valid = -1;
    for (int i = 0; i < 6; i++) begin
      strobe(8 * i + 3, 130, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, e);
      if (VGA_BLANK_N === 1'b1 && first_valid < 0) first_valid = i;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    checks++;
    if (first_valid !== 3) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d expected 3", first_valid);
    end
  endtask

  initial begin
    test_reset();
    init_buffer();
    test_border_blank();
    test_glyph();
    test_cursor_on();
    test_out_of_range();
    test_cursor_off();
    test_back_to_back();
    test_random();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
